// File: rtl/conv_coprocessor_param.sv
// Parametrised 1-D convolution coprocessor on the ipm IP-side bus.
// X and Y are loaded through auto-incrementing pointers, Z = X*Y is computed one tap per cycle.
module conv_coprocessor_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int CONF_WIDTH   = 5,
    parameter int SAMPLE_WIDTH = 8,
    parameter int ADDR_X       = 5,
    parameter int ADDR_Y       = 5,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_s,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  write,
    input  logic                  read,
    input  logic                  start,
    input  logic [CONF_WIDTH-1:0] conf_dbus,
    output logic                  int_req
);
    localparam int DEPTH_X = 1 << ADDR_X;
    localparam int DEPTH_Y = 1 << ADDR_Y;
    localparam int DEPTH_Z = DEPTH_X + DEPTH_Y - 1;
    localparam int ADDR_Z  = $clog2(DEPTH_Z);
    localparam int LXW     = ADDR_X + 1;
    localparam int LYW     = ADDR_Y + 1;
    localparam int NSW     = ADDR_Z + 1;
    localparam int PROD_W  = 2 * SAMPLE_WIDTH + 2;
    localparam int ACC_W   = 2 * SAMPLE_WIDTH + ADDR_Y + 1;

    localparam logic [CONF_WIDTH-1:0] CONF_MEMX   = CONF_WIDTH'(0);
    localparam logic [CONF_WIDTH-1:0] CONF_MEMY   = CONF_WIDTH'(1);
    localparam logic [CONF_WIDTH-1:0] CONF_MEMZ   = CONF_WIDTH'(2);
    localparam logic [CONF_WIDTH-1:0] CONF_SIZE   = CONF_WIDTH'(3);
    localparam logic [CONF_WIDTH-1:0] CONF_CTRL   = CONF_WIDTH'(4);
    localparam logic [CONF_WIDTH-1:0] CONF_STATUS = CONF_WIDTH'(5);

    localparam logic signed [ACC_W-1:0] SAT_SMAX = ACC_W'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_SMIN = ~SAT_SMAX;
    localparam logic signed [ACC_W-1:0] SAT_UMAX = ACC_W'((1 << OUT_WIDTH) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [SAMPLE_WIDTH-1:0] x_mem_r [DEPTH_X];
    logic [SAMPLE_WIDTH-1:0] y_mem_r [DEPTH_Y];
    logic [OUT_WIDTH-1:0]    z_mem_r [DEPTH_Z];

    state_t                  state_r, state_nx_s;
    logic [15:0]             len_x_r, len_y_r;
    logic                    signed_r, sat_r, int_en_r, done_r, ovf_r, int_req_r;
    logic [DATA_WIDTH-1:0]   data_out_r;
    logic [ADDR_X-1:0]       ptr_x_r;
    logic [ADDR_Y-1:0]       ptr_y_r;
    logic [ADDR_Z-1:0]       ptr_z_r;
    logic [LXW-1:0]          lx_r;
    logic [LYW-1:0]          ly_r;
    logic [ADDR_Z-1:0]       n_r;
    logic [NSW-1:0]          n_last_r;
    logic [LYW-1:0]          k_r;
    logic signed [ACC_W-1:0] acc_r;

    logic                    busy_s, wr_ok_s, start_ok_s, status_clr_s, zero_len_s;
    logic [LXW-1:0]          lx_clamp_s;
    logic [LYW-1:0]          ly_clamp_s;
    logic [NSW-1:0]          len_sum_s, nk_diff_s;
    logic                    tap_valid_s, k_last_s, n_last_hit_s;
    logic [SAMPLE_WIDTH-1:0] x_samp_s, y_samp_s;
    logic [SAMPLE_WIDTH:0]   x_ext_s, y_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0] tap_s;
    logic [OUT_WIDTH-1:0]    store_val_s, z_word_s;
    logic                    clamp_s;
    logic                    done_nx_s, ovf_nx_s, int_en_nx_s;
    logic [DATA_WIDTH-1:0]   z_ext_s, rd_data_s;

    assign data_out = data_out_r;
    assign int_req  = int_req_r;

    assign busy_s       = (state_r != ST_IDLE);
    assign wr_ok_s      = write & ~busy_s;
    assign start_ok_s   = start & ~busy_s & ~write;
    assign status_clr_s = wr_ok_s & (conf_dbus == CONF_STATUS) & data_in[1];

    // Clamp the programmed lengths to the memory depths and derive the last output index
    always_comb begin
        if (len_x_r > 16'(DEPTH_X)) begin
            lx_clamp_s = LXW'(DEPTH_X);
        end else begin
            lx_clamp_s = len_x_r[LXW-1:0];
        end
        if (len_y_r > 16'(DEPTH_Y)) begin
            ly_clamp_s = LYW'(DEPTH_Y);
        end else begin
            ly_clamp_s = len_y_r[LYW-1:0];
        end
        zero_len_s = (lx_clamp_s == LXW'(0)) | (ly_clamp_s == LYW'(0));
        len_sum_s  = NSW'(lx_clamp_s) + NSW'(ly_clamp_s) - NSW'(2);
    end

    // One convolution tap: X[n-k]*Y[k], zero when n-k falls outside the X window
    always_comb begin
        nk_diff_s   = NSW'(n_r) - NSW'(k_r);
        tap_valid_s = (NSW'(n_r) >= NSW'(k_r)) && (nk_diff_s < NSW'(lx_r));
        x_samp_s    = x_mem_r[nk_diff_s[ADDR_X-1:0]];
        y_samp_s    = y_mem_r[k_r[ADDR_Y-1:0]];
        if (signed_r) begin
            x_ext_s = {x_samp_s[SAMPLE_WIDTH-1], x_samp_s};
            y_ext_s = {y_samp_s[SAMPLE_WIDTH-1], y_samp_s};
        end else begin
            x_ext_s = {1'b0, x_samp_s};
            y_ext_s = {1'b0, y_samp_s};
        end
        prod_s = $signed(x_ext_s) * $signed(y_ext_s);
        if (tap_valid_s) begin
            tap_s = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};
        end else begin
            tap_s = '0;
        end
        k_last_s     = (k_r == ly_r - LYW'(1));
        n_last_hit_s = (NSW'(n_r) == n_last_r);
    end

    // Narrow the accumulator to OUT_WIDTH, either wrapping or clamping
    always_comb begin
        store_val_s = acc_r[OUT_WIDTH-1:0];
        clamp_s     = 1'b0;
        if (sat_r) begin
            if (signed_r) begin
                if (acc_r > SAT_SMAX) begin
                    store_val_s = SAT_SMAX[OUT_WIDTH-1:0];
                    clamp_s     = 1'b1;
                end else if (acc_r < SAT_SMIN) begin
                    store_val_s = SAT_SMIN[OUT_WIDTH-1:0];
                    clamp_s     = 1'b1;
                end else begin
                    store_val_s = acc_r[OUT_WIDTH-1:0];
                    clamp_s     = 1'b0;
                end
            end else begin
                if (acc_r[ACC_W-1]) begin
                    store_val_s = '0;
                    clamp_s     = 1'b1;
                end else if (acc_r > SAT_UMAX) begin
                    store_val_s = SAT_UMAX[OUT_WIDTH-1:0];
                    clamp_s     = 1'b1;
                end else begin
                    store_val_s = acc_r[OUT_WIDTH-1:0];
                    clamp_s     = 1'b0;
                end
            end
        end else begin
            store_val_s = acc_r[OUT_WIDTH-1:0];
            clamp_s     = 1'b0;
        end
    end

    // Next-state logic of the sequencer
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nx_s = zero_len_s ? ST_DONE : ST_MAC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (k_last_s) begin
                    state_nx_s = ST_STORE;
                end else begin
                    state_nx_s = ST_MAC;
                end
            end
            ST_STORE: begin
                if (n_last_hit_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_MAC;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Next values of the done/overflow flags and interrupt enable
    always_comb begin
        done_nx_s   = done_r;
        ovf_nx_s    = ovf_r;
        int_en_nx_s = int_en_r;
        if (start_ok_s || status_clr_s) begin
            done_nx_s = 1'b0;
            ovf_nx_s  = 1'b0;
        end else if (state_r == ST_STORE) begin
            done_nx_s = done_r;
            ovf_nx_s  = ovf_r | clamp_s;
        end else if (state_r == ST_DONE) begin
            done_nx_s = 1'b1;
            ovf_nx_s  = ovf_r;
        end else begin
            done_nx_s = done_r;
            ovf_nx_s  = ovf_r;
        end
        if (wr_ok_s && (conf_dbus == CONF_CTRL)) begin
            int_en_nx_s = data_in[2];
        end else begin
            int_en_nx_s = int_en_r;
        end
    end

    // Read-data multiplexer
    always_comb begin
        z_word_s = z_mem_r[ptr_z_r];
        if (signed_r) begin
            z_ext_s = {{(DATA_WIDTH - OUT_WIDTH){z_word_s[OUT_WIDTH-1]}}, z_word_s};
        end else begin
            z_ext_s = {{(DATA_WIDTH - OUT_WIDTH){1'b0}}, z_word_s};
        end
        rd_data_s = '0;
        case (conf_dbus)
            CONF_MEMZ:   rd_data_s = z_ext_s;
            CONF_SIZE:   rd_data_s = DATA_WIDTH'({len_y_r, len_x_r});
            CONF_CTRL:   rd_data_s = DATA_WIDTH'({int_en_r, sat_r, signed_r});
            CONF_STATUS: rd_data_s = DATA_WIDTH'({ovf_r, done_r, busy_s});
            default:     rd_data_s = '0;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (en_s) begin
            state_r <= state_nx_s;
        end
    end

    // Host registers, flags, pointers and the registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            len_x_r    <= 16'd0;
            len_y_r    <= 16'd0;
            signed_r   <= 1'b0;
            sat_r      <= 1'b0;
            int_en_r   <= 1'b0;
            done_r     <= 1'b0;
            ovf_r      <= 1'b0;
            int_req_r  <= 1'b0;
            data_out_r <= '0;
            ptr_x_r    <= '0;
            ptr_y_r    <= '0;
            ptr_z_r    <= '0;
        end else if (en_s) begin
            done_r    <= done_nx_s;
            ovf_r     <= ovf_nx_s;
            int_en_r  <= int_en_nx_s;
            int_req_r <= done_nx_s & int_en_nx_s;
            if (wr_ok_s) begin
                case (conf_dbus)
                    CONF_MEMX: ptr_x_r <= ptr_x_r + ADDR_X'(1);
                    CONF_MEMY: ptr_y_r <= ptr_y_r + ADDR_Y'(1);
                    CONF_SIZE: begin
                        len_x_r <= data_in[15:0];
                        len_y_r <= data_in[31:16];
                    end
                    CONF_CTRL: begin
                        signed_r <= data_in[0];
                        sat_r    <= data_in[1];
                        if (data_in[3]) begin
                            ptr_x_r <= '0;
                            ptr_y_r <= '0;
                            ptr_z_r <= '0;
                        end
                    end
                    default: ;
                endcase
            end
            // A MEMZ read during a run neither updates data_out nor moves the pointer
            if (read) begin
                if (conf_dbus == CONF_MEMZ) begin
                    if (!busy_s) begin
                        data_out_r <= rd_data_s;
                        ptr_z_r    <= (ptr_z_r == ADDR_Z'(DEPTH_Z - 1)) ? '0 : ptr_z_r + ADDR_Z'(1);
                    end
                end else begin
                    data_out_r <= rd_data_s;
                end
            end
            if (start_ok_s) begin
                ptr_z_r <= '0;
            end
        end
    end

    // MAC datapath: accumulator, tap and output indices
    always_ff @(posedge clk) begin
        if (rst) begin
            lx_r     <= '0;
            ly_r     <= '0;
            n_r      <= '0;
            n_last_r <= '0;
            k_r      <= '0;
            acc_r    <= '0;
        end else if (en_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        lx_r     <= lx_clamp_s;
                        ly_r     <= ly_clamp_s;
                        n_last_r <= len_sum_s;
                        n_r      <= '0;
                        k_r      <= '0;
                        acc_r    <= '0;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_r + tap_s;
                    k_r   <= k_r + LYW'(1);
                end
                ST_STORE: begin
                    acc_r <= '0;
                    k_r   <= '0;
                    n_r   <= n_r + ADDR_Z'(1);
                end
                default: ;
            endcase
        end
    end

    // Sample memories; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && en_s) begin
            if (wr_ok_s && (conf_dbus == CONF_MEMX)) begin
                x_mem_r[ptr_x_r] <= data_in[SAMPLE_WIDTH-1:0];
            end
            if (wr_ok_s && (conf_dbus == CONF_MEMY)) begin
                y_mem_r[ptr_y_r] <= data_in[SAMPLE_WIDTH-1:0];
            end
            if (state_r == ST_STORE) begin
                z_mem_r[n_r] <= store_val_s;
            end
        end
    end

endmodule

// File: tb/tb_conv_coprocessor_param.sv
// Directed self-checking bench for conv_coprocessor_param: bus access, convolution
// results, latency, saturation, busy protection and boundary cases.
module tb_conv_coprocessor_param;
    localparam logic [4:0] C_MEMX   = 5'h00;
    localparam logic [4:0] C_MEMY   = 5'h01;
    localparam logic [4:0] C_MEMZ   = 5'h02;
    localparam logic [4:0] C_SIZE   = 5'h03;
    localparam logic [4:0] C_CTRL   = 5'h04;
    localparam logic [4:0] C_STATUS = 5'h05;

    logic        clk = 1'b0;
    logic        rst, en_s, write, read, start, int_req;
    logic [31:0] data_in, data_out;
    logic [4:0]  conf_dbus;

    int          checks   = 0;
    int          failures = 0;
    int          cyc_cnt  = 0;
    int          t0       = 0;
    int          lat;
    logic [31:0] rdv;
    logic [31:0] exp_basic [4] = '{32'd1, 32'd3, 32'd5, 32'd3};

    conv_coprocessor_param dut (
        .clk      (clk),
        .rst      (rst),
        .en_s     (en_s),
        .data_in  (data_in),
        .data_out (data_out),
        .write    (write),
        .read     (read),
        .start    (start),
        .conf_dbus(conf_dbus),
        .int_req  (int_req)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic wr(input logic [4:0] c, input logic [31:0] d);
        @(negedge clk);
        conf_dbus = c;
        data_in   = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [4:0] c, output logic [31:0] d);
        @(negedge clk);
        conf_dbus = c;
        read      = 1'b1;
        @(negedge clk);
        read      = 1'b0;
        d         = data_out;
    endtask

    task automatic strobe_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go();
        strobe_start();
        t0 = cyc_cnt;
    endtask

    task automatic wait_irq(input int budget, output int l);
        while (int_req !== 1'b1 && (cyc_cnt - t0) < budget) @(negedge clk);
        l = cyc_cnt - t0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
        data_in = 32'd0; conf_dbus = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_int_req", {31'd0, int_req}, 32'd0);
        rd(C_STATUS, rdv); chk("reset_status", rdv, 32'd0);
        rd(C_SIZE, rdv);   chk("reset_size", rdv, 32'd0);

        // Basic unsigned convolution
        wr(C_CTRL, 32'hC);
        rd(C_CTRL, rdv); chk("ctrl_ptrclr_reads0", rdv, 32'h4);
        wr(C_MEMX, 32'd1); wr(C_MEMX, 32'd2); wr(C_MEMX, 32'd3);
        wr(C_MEMY, 32'd1); wr(C_MEMY, 32'd1);
        wr(C_SIZE, 32'h0002_0003);
        go();
        wait_irq(5000, lat);
        chk("basic_latency", lat, 32'd13);
        chk("basic_int_req", {31'd0, int_req}, 32'd1);
        rd(C_STATUS, rdv); chk("basic_status_done", rdv, 32'h2);
        wr(C_CTRL, 32'hC);
        for (int i = 0; i < 4; i++) begin
            rd(C_MEMZ, rdv); chk($sformatf("basic_z%0d", i), rdv, exp_basic[i]);
        end

        // Busy protection: writes and start during a run are dropped
        go();
        repeat (2) @(negedge clk);
        wr(C_MEMX, 32'h55);
        wr(C_SIZE, 32'd0);
        strobe_start();
        rd(C_STATUS, rdv); chk("busy_status", rdv, 32'h1);
        wait_irq(5000, lat);
        chk("busy_latency", lat, 32'd13);
        rd(C_SIZE, rdv); chk("busy_size_kept", rdv, 32'h0002_0003);
        wr(C_CTRL, 32'hC);
        for (int i = 0; i < 4; i++) begin
            rd(C_MEMZ, rdv); chk($sformatf("busy_z%0d", i), rdv, exp_basic[i]);
        end

        // STATUS clear drops done and int_req
        wr(C_STATUS, 32'h2);
        chk("clr_int_req", {31'd0, int_req}, 32'd0);
        rd(C_STATUS, rdv); chk("clr_status", rdv, 32'd0);

        // Signed convolution
        wr(C_CTRL, 32'hD);
        rd(C_CTRL, rdv); chk("signed_ctrl", rdv, 32'h5);
        wr(C_MEMX, 32'hFF); wr(C_MEMX, 32'd2);
        wr(C_MEMY, 32'd3);
        wr(C_SIZE, 32'h0001_0002);
        go();
        wait_irq(5000, lat);
        chk("signed_latency", lat, 32'd5);
        wr(C_CTRL, 32'hD);
        rd(C_MEMZ, rdv); chk("signed_z0", rdv, 32'hFFFF_FFFD);
        rd(C_MEMZ, rdv); chk("signed_z1", rdv, 32'h0000_0006);

        // Full-length run with saturation
        wr(C_CTRL, 32'hF);
        for (int i = 0; i < 32; i++) wr(C_MEMX, 32'h7F);
        for (int i = 0; i < 32; i++) wr(C_MEMY, 32'h7F);
        wr(C_SIZE, 32'h0020_0020);
        go();
        wait_irq(5000, lat);
        chk("sat_latency", lat, 32'd2080);
        rd(C_STATUS, rdv); chk("sat_status_ovf", rdv, 32'h6);
        wr(C_CTRL, 32'hF);
        rd(C_MEMZ, rdv); chk("sat_z0", rdv, 32'h0000_3F01);
        for (int i = 1; i < 32; i++) rd(C_MEMZ, rdv);
        chk("sat_z31", rdv, 32'h0000_7FFF);

        // Same run wrapping
        wr(C_CTRL, 32'hD);
        go();
        wait_irq(5000, lat);
        chk("wrap_latency", lat, 32'd2080);
        rd(C_STATUS, rdv); chk("wrap_status_no_ovf", rdv, 32'h2);
        wr(C_CTRL, 32'hD);
        for (int i = 0; i < 32; i++) rd(C_MEMZ, rdv);
        chk("wrap_z31", rdv, 32'hFFFF_E020);

        // Zero-length start
        wr(C_SIZE, 32'd0);
        go();
        wait_irq(100, lat);
        chk("zero_len_latency", lat, 32'd1);
        rd(C_STATUS, rdv); chk("zero_len_status", rdv, 32'h2);

        // X pointer wraps after 2^ADDR_X writes
        wr(C_CTRL, 32'hC);
        for (int i = 1; i <= 33; i++) wr(C_MEMX, i);
        wr(C_MEMY, 32'd1);
        wr(C_SIZE, 32'h0001_0001);
        go();
        wait_irq(100, lat);
        chk("ptrwrap_latency", lat, 32'd3);
        wr(C_CTRL, 32'hC);
        rd(C_MEMZ, rdv); chk("ptrwrap_x0", rdv, 32'd33);

        rd(5'h1F, rdv); chk("unknown_conf_read", rdv, 32'd0);

        // Reset in the middle of a run
        wr(C_SIZE, 32'h0020_0020);
        go();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd(C_STATUS, rdv); chk("midrst_status", rdv, 32'd0);
        rd(C_SIZE, rdv);   chk("midrst_size", rdv, 32'd0);
        chk("midrst_int_req", {31'd0, int_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
